// File: rtl/db15_joy_tx.sv
// DB15 joystick serial responder: emulates the adapter's PISO chain,
// shifting two 12-bit button words out under an external load/clock.
module db15_joy_tx #(
  parameter int TIMEOUT = 480000,
  parameter int CNT_W   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  output logic [4:0]  bit_idx,
  output logic        frame_done,
  output logic        idle
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [4:0] LAST = 5'd24;

  logic             clk_m_q, clk_s_q, clk_e_q;
  logic             load_m_q, load_s_q;
  logic [23:0]      sr_q, sr_d;
  logic [4:0]       bidx_q, bidx_d;
  logic             fd_q, fd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle_q, idle_d;
  logic             rise;

  // Sync flops reset high so a line idling high never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_m_q  <= 1'b1;
      clk_s_q  <= 1'b1;
      clk_e_q  <= 1'b1;
      load_m_q <= 1'b1;
      load_s_q <= 1'b1;
    end else begin
      clk_m_q  <= joy_clk;
      clk_s_q  <= clk_m_q;
      clk_e_q  <= clk_s_q;
      load_m_q <= joy_load;
      load_s_q <= load_m_q;
    end
  end

  assign rise = clk_s_q & ~clk_e_q;

  always_comb begin
    sr_d   = sr_q;
    bidx_d = bidx_q;
    fd_d   = 1'b0;
    cnt_d  = cnt_q;
    idle_d = 1'b0;
    if (!load_s_q) begin
      sr_d   = ~{joystick2, joystick1};
      bidx_d = 5'd0;
      cnt_d  = '0;
    end else begin
      if (cnt_q != TO)
        cnt_d = cnt_q + 1'b1;
      idle_d = (cnt_q == TO);
      if (rise) begin
        sr_d = {1'b1, sr_q[23:1]};
        if (bidx_q != LAST)
          bidx_d = bidx_q + 5'd1;
        fd_d = (bidx_q == 5'd23);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '1;
      bidx_q <= 5'd0;
      fd_q   <= 1'b0;
      cnt_q  <= '0;
      idle_q <= 1'b1;
    end else begin
      sr_q   <= sr_d;
      bidx_q <= bidx_d;
      fd_q   <= fd_d;
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
    end
  end

  assign joy_data   = sr_q[0];
  assign bit_idx    = bidx_q;
  assign frame_done = fd_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_db15_joy_tx.sv
// Scoreboard bench for db15_joy_tx: a master model queues expected
// line/index/idle values, a negedge monitor pops and compares them.
module tb_db15_joy_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] j1 = '0;
  logic [11:0] j2 = '0;
  logic        jclk = 1'b0;
  logic        jload = 1'b0;
  logic        jdata;
  logic [4:0]  bidx;
  logic        fdone;
  logic        idle;

  db15_joy_tx #(
    .TIMEOUT(100),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .joystick1(j1),
    .joystick2(j2),
    .joy_clk(jclk),
    .joy_load(jload),
    .joy_data(jdata),
    .bit_idx(bidx),
    .frame_done(fdone),
    .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    kind;
    int    exp;
    string name;
  } item_t;

  item_t q[$];
  logic  smp = 1'b0;
  int    n_run = 0;
  int    n_fail = 0;
  int    fd_cnt = 0;

  always @(negedge clk) begin
    if (fdone) begin
      fd_cnt++;
      n_run++;
      if (bidx != 5'd24) begin
        n_fail++;
        $display("FAIL fd_idx: got %0d want 24", bidx);
      end
    end
    if (smp) begin
      while (q.size() > 0) begin
        item_t it;
        int act;
        it = q.pop_front();
        case (it.kind)
          0: act = int'(jdata);
          1: act = int'(bidx);
          2: act = int'(idle);
          3: act = fd_cnt;
          default: act = int'(fdone);
        endcase
        n_run++;
        if (act != it.exp) begin
          n_fail++;
          $display("FAIL %s: got %0d want %0d",
                   it.name, act, it.exp);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int e,
                      input string nm);
    item_t it;
    it.kind = k;
    it.exp  = e;
    it.name = nm;
    q.push_back(it);
  endtask

  task automatic strobe();
    smp = 1'b1;
    @(posedge clk);
    #1;
    smp = 1'b0;
  endtask

  task automatic load_pulse(input logic [23:0] ex);
    jload = 1'b0;
    cyc(3);
    push(0, int'(ex[0]), "ld_bit0");
    push(1, 0, "ld_idx");
    strobe();
    jload = 1'b1;
    cyc(3);
  endtask

  task automatic shift_chk(input int k,
                           input logic [23:0] ex);
    int b;
    b = (k < 24) ? int'(ex[k]) : 1;
    jclk = 1'b1;
    cyc(3);
    push(0, b, $sformatf("bit%0d", k));
    push(1, (k > 24) ? 24 : k,
         $sformatf("idx%0d", k));
    strobe();
    jclk = 1'b0;
    cyc(4);
  endtask

  logic [23:0] e1 = 24'hBFFFEE;
  logic [23:0] e2 = 24'hFFFF0F;
  logic [23:0] e3 = 24'hFFD7FE;
  logic [23:0] e4 = 24'hC3C5A5;

  initial begin
    cyc(1);
    for (int i = 0; i < 2; i++) begin
      jclk = ~jclk;
      push(0, 1, "rst_data");
      push(1, 0, "rst_idx");
      push(2, 1, "rst_idle");
      push(4, 0, "rst_fd");
      strobe();
    end
    jclk = 1'b0;
    jload = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(4);
    push(3, 0, "fd_none");
    strobe();

    j1 = 12'h011;
    j2 = 12'h400;
    load_pulse(e1);
    for (int k = 1; k <= 24; k++)
      shift_chk(k, e1);
    push(3, 1, "fd_once");
    strobe();
    for (int k = 25; k <= 29; k++)
      shift_chk(k, e1);
    push(3, 1, "fd_over");
    strobe();

    j1 = 12'h0F0;
    j2 = 12'h000;
    load_pulse(e2);
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) begin
        j1 = 12'h801;
        j2 = 12'h002;
      end
      shift_chk(k, e2);
    end
    jclk = 1'b1;
    jload = 1'b0;
    cyc(3);
    push(1, 0, "prio_idx");
    push(0, int'(e3[0]), "prio_bit0");
    strobe();
    jload = 1'b1;
    cyc(3);
    jclk = 1'b0;
    cyc(4);
    push(1, 0, "prio_hold");
    strobe();
    for (int k = 1; k <= 24; k++)
      shift_chk(k, e3);
    push(3, 2, "fd_reload");
    strobe();

    jload = 1'b0;
    cyc(4);
    jload = 1'b1;
    cyc(102);
    push(2, 0, "idle_100");
    strobe();
    push(2, 1, "idle_101");
    strobe();
    cyc(5);
    push(2, 1, "idle_sat");
    strobe();
    jload = 1'b0;
    cyc(2);
    push(2, 1, "idle_ld2");
    strobe();
    push(2, 0, "idle_clr");
    strobe();
    jload = 1'b1;
    cyc(3);

    j1 = 12'hA5A;
    j2 = 12'h3C3;
    load_pulse(e4);
    for (int k = 1; k <= 10; k++)
      shift_chk(k, e4);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    push(0, 1, "mrst_data");
    push(1, 0, "mrst_idx");
    push(2, 1, "mrst_idle");
    strobe();
    cyc(3);
    load_pulse(e4);
    for (int k = 1; k <= 24; k++)
      shift_chk(k, e4);
    push(3, 3, "fd_after_rst");
    strobe();
    cyc(2);

    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d left want 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
